// File: rtl/uart_pkg.sv
// Shared UART constants, scheduler state type and the default baud divider helper.
// Usable by both the 8N1 transmitter and its front-end scheduler.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int SYNC_LAT   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    // Rounded-to-nearest clock cycles per bit.
    function automatic logic [31:0] p_div(input longint clk_freq, input longint baud);
        return 32'((clk_freq + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// N-way request picker: round-robin by default, fixed lowest-index priority when
// UART_SCHED_FIXED_PRIO_EN is defined. Outputs a one-hot grant plus its index.
module uart_rr_arb #(
    parameter int N_REQ = 3,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

`ifdef UART_SCHED_FIXED_PRIO_EN
    logic unused_fixed;
    assign unused_fixed = ^{clk, reset_n, advance};

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !gnt_any) begin
                gnt_idx = IW'(i);
                gnt_any = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Search starts at the requester after the last grant and wraps around.
    always_comb begin
        int j;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j] && !gnt_any) begin
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_any && (int'(gnt_idx) == i)) begin
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester scheduler in front of the edge-started 8N1 UART transmitter; times
// each frame slot internally. Define UART_SCHED_FIXED_PRIO_EN for fixed priority.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int GAP_BITS   = 1,
    parameter int START_HOLD = 4,
    parameter int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [31:0]        baud_div_i,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic [31:0]        tx_baud_div,
    output logic               busy,
    output logic [IW-1:0]      grant_id
);

    localparam logic [31:0] P_DIV      = p_div(longint'(CLK_FREQ), longint'(BAUD));
    localparam logic [39:0] START_LAST = 40'(START_HOLD - 1);
    localparam logic [39:0] BIT_SLOTS  = 40'(FRAME_BITS + GAP_BITS);

    sched_state_e       state_q, state_d;
    logic [39:0]        cnt_q, cnt_d;
    logic [39:0]        last_q, last_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [31:0]        tx_baud_div_q, tx_baud_div_d;
    logic               busy_q, busy_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;

    logic [N_REQ-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               advance;
    logic [31:0]        div_eff;
    logic [39:0]        frame_cyc;

    assign div_eff   = (baud_div_i != 32'd0) ? baud_div_i : P_DIV;
    assign frame_cyc = 40'(SYNC_LAT) + BIT_SLOTS * {8'd0, div_eff};

    uart_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        tx_baud_div_d = tx_baud_div_q;
        busy_d        = busy_q;
        grant_id_d    = grant_id_q;
        req_ready_d   = '0;
        advance       = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    advance       = 1'b1;
                    req_ready_d   = gnt;
                    tx_start_d    = 1'b1;
                    busy_d        = 1'b1;
                    grant_id_d    = gnt_idx;
                    tx_baud_div_d = div_eff;
                    last_d        = frame_cyc - 40'd1;
                    cnt_d         = '0;
                    state_d       = SEND;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt[i]) begin
                            tx_data_d = req_data[8*i +: 8];
                        end
                    end
                end
            end
            SEND: begin
                // Slot length is frozen at grant, so divider changes wait for the next frame.
                cnt_d      = cnt_q + 40'd1;
                tx_start_d = (cnt_q < START_LAST);
                if (cnt_q == last_q) begin
                    cnt_d      = '0;
                    tx_start_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_baud_div_q <= P_DIV;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            req_ready_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            tx_baud_div_q <= tx_baud_div_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign tx_baud_div = tx_baud_div_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign req_ready   = req_ready_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched: a slot-level reference model predicts
// each grant (winner, byte, divider, frame length, start time) and a monitor checks it.
module tb_uart_tx_sched;

    localparam int N        = 3;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int GAP      = 1;
    localparam int HOLD     = 4;
    localparam int PDIV     = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int IW       = 2;

    localparam int OFF  = 0;
    localparam int CONT = 1;
    localparam int RAND = 2;
    localparam int ONCE = 3;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [31:0]    baud_div_i;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [31:0]    tx_baud_div;
    logic           busy;
    logic [IW-1:0]  grant_id;

    typedef struct {
        int         idx;
        logic [7:0] data;
        longint     div;
        longint     frame;
        longint     rise;
    } exp_t;

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    longint     cyc;
    int         mode[N];
    bit [N-1:0] once_pend;
    logic [7:0] once_data[N];
    bit         rand_div;
    bit         in_reset;
    longint     next_free;
    int         ptr;

    uart_tx_sched #(
        .N_REQ      (N),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .GAP_BITS   (GAP),
        .START_HOLD (HOLD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .baud_div_i  (baud_div_i),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_baud_div (tx_baud_div),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Requester behaviour: drop valid on accept, then act according to the current mode.
    task automatic applyStimulus();
        if (rand_div && $urandom_range(0, 9) == 0) begin
            baud_div_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) req_valid[i] = 1'b0;
            case (mode[i])
                OFF: req_valid[i] = 1'b0;
                CONT: begin
                    if (!req_valid[i]) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
                RAND: begin
                    if (req_valid[i]) begin
                        if ($urandom_range(0, 24) == 0) req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
                ONCE: begin
                    if (once_pend[i] && !req_valid[i]) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = once_data[i];
                        once_pend[i] = 1'b0;
                    end
                end
                default: req_valid[i] = 1'b0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    end

    // Reference model: a free slot plus any pending request produces one grant whose
    // frame length follows from the divider; the next decision is one idle cycle later.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        if (!in_reset && cyc >= next_free && req_valid != '0) begin
            w = -1;
`ifdef UART_SCHED_FIXED_PRIO_EN
            for (int i = 0; i < N; i++) if (req_valid[i] && w < 0) w = i;
`else
            for (int k = 0; k < N; k++) if (req_valid[(ptr + k) % N] && w < 0) w = (ptr + k) % N;
`endif
            e.idx   = w;
            e.data  = req_data[8*w +: 8];
            e.div   = (baud_div_i == 0) ? longint'(PDIV) : longint'(baud_div_i);
            e.frame = 3 + (10 + GAP) * e.div;
            e.rise  = cyc + 1;
            exp_q.push_back(e);
            next_free = cyc + e.frame + 1;
            ptr = (w + 1) % N;
        end
    end

    // Monitor: every tx_start rising edge consumes one predicted grant.
    exp_t   cur;
    bit     have_cur;
    bit     prev_start;
    bit     prev_busy;
    longint start_len;
    longint busy_len;

    always @(negedge clk) begin
        if (in_reset) begin
            have_cur   = 1'b0;
            prev_start = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (tx_start && !prev_start) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_start", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur  = 1'b1;
                    start_len = 0;
                    busy_len  = 0;
                    checkOutput("grant_id", grant_id, cur.idx);
                    checkOutput("tx_data", tx_data, cur.data);
                    checkOutput("tx_baud_div", tx_baud_div, cur.div);
                    checkOutput("req_ready_pulse", req_ready, 64'd1 << cur.idx);
                    checkOutput("start_cycle", cyc, cur.rise);
                    checkOutput("busy_at_start", busy, 1);
                end
            end else if (req_ready != '0) begin
                checkOutput("req_ready_stray", req_ready, 0);
            end
            if (have_cur) begin
                if (tx_start) start_len++;
                if (busy) begin
                    busy_len++;
                    checkOutput("baud_hold", tx_baud_div, cur.div);
                end
                if (prev_start && !tx_start) checkOutput("start_len", start_len, HOLD);
                if (prev_busy && !busy) begin
                    checkOutput("busy_len", busy_len, cur.frame);
                    have_cur = 1'b0;
                end
            end
            prev_start = tx_start;
            prev_busy  = busy;
        end
    end

    task automatic wait_quiet(input int max_cyc);
        int q;
        q = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy && req_valid == '0 && exp_q.size() == 0 && once_pend == '0) q++;
            else q = 0;
            if (q >= 3) return;
        end
        checkOutput("drain_timeout", 0, 1);
    endtask

    task automatic wait_rise(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (tx_start) return;
        end
        checkOutput("start_timeout", 0, 1);
    endtask

    task automatic set_modes(input int m);
        for (int i = 0; i < N; i++) mode[i] = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_tx_start"}, tx_start, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_req_ready"}, req_ready, 0);
        checkOutput({tag, "_tx_data"}, tx_data, 0);
        checkOutput({tag, "_grant_id"}, grant_id, 0);
        checkOutput({tag, "_tx_baud_div"}, tx_baud_div, PDIV);
    endtask

    task automatic send_once(input int i, input logic [7:0] d);
        once_data[i] = d;
        once_pend[i] = 1'b1;
        mode[i] = ONCE;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        in_reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        baud_div_i = '0;
        rand_div = 1'b0;
        once_pend = '0;
        next_free = 0;
        ptr = 0;
        set_modes(OFF);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        in_reset = 1'b0;

        $display("[TB] single byte 0x55 from requester 0");
        send_once(0, 8'h55);
        wait_quiet(500);

        $display("[TB] all requesters continuously valid");
        set_modes(CONT);
        repeat (1200) @(posedge clk);
        set_modes(OFF);
        wait_quiet(500);

        $display("[TB] random traffic with random divider");
        rand_div = 1'b1;
        set_modes(RAND);
        repeat (3000) @(posedge clk);
        set_modes(OFF);
        #1;
        rand_div = 1'b0;
        baud_div_i = 32'd0;
        wait_quiet(500);

        $display("[TB] divider 20 changed to 5 mid-frame");
        baud_div_i = 32'd20;
        send_once(1, 8'h3C);
        wait_rise(100);
        repeat (10) @(posedge clk);
        #1;
        baud_div_i = 32'd5;
        send_once(2, 8'hC3);
        wait_quiet(1000);
        baud_div_i = 32'd0;

        $display("[TB] reset in the middle of a frame");
        send_once(0, 8'h81);
        wait_rise(100);
        repeat (40) @(posedge clk);
        #3;
        reset_n = 1'b0;
        in_reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        next_free = 0;
        ptr = 0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        in_reset = 1'b0;
        send_once(1, 8'h7E);
        wait_quiet(500);

        $display("[TB] closing random traffic");
        set_modes(RAND);
        repeat (1500) @(posedge clk);
        set_modes(OFF);
        wait_quiet(500);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
